// File: rtl/lsu_pkg.sv
// Shared types and constants for the riscv_lsu load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_e;

    localparam logic [1:0] CAUSE_OK       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational access check, byte-enable / store-lane generation and load extraction.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [2:0]       funct,
    input  logic             we,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic             legal,
    output logic [BE_W-1:0]  be,
    output logic [XLEN-1:0]  wdata_lane,
    output logic [XLEN-1:0]  rdata_ext
);

    size_e            size;
    logic [3:0]       nbytes;
    logic [6:0]       sbits;
    logic             illegal;
    logic             misaligned;
    logic [BE_W-1:0]  size_mask;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep;
    logic [XLEN-1:0]  top_bit;
    logic             sign;

    assign size   = size_e'(funct[1:0]);
    assign nbytes = size_bytes(size);
    assign sbits  = {nbytes, 3'b000};

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        illegal = 1'b0;
        if (XLEN == 32 && (size == SZ_D || funct == F3_WU))
            illegal = 1'b1;
        if (we && funct[2])
            illegal = 1'b1;
    end

    assign misaligned = |(offset & OFF_W'(nbytes - 4'd1));
    assign legal      = !illegal && !misaligned;

    always_comb begin
        unique case (size)
            SZ_B: size_mask = BE_W'(8'h01);
            SZ_H: size_mask = BE_W'(8'h03);
            SZ_W: size_mask = BE_W'(8'h0F);
            SZ_D: size_mask = BE_W'(8'hFF);
        endcase
    end

    assign be         = size_mask << offset;
    assign wdata_lane = wdata << {offset, 3'b000};

    // The sign bit is the top bit of the size mask, which avoids a variable bit-select.
    assign shifted   = rdata >> {offset, 3'b000};
    assign keep      = (sbits >= 7'(XLEN)) ? '1 : ~({XLEN{1'b1}} << sbits);
    assign top_bit   = keep & ~(keep >> 1);
    assign sign      = |(shifted & top_bit);
    assign rdata_ext = (!funct[2] && sign) ? (shifted | ~keep) : (shifted & keep);

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: valid/ready core side, req/gnt/rvalid memory side.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu
    import lsu_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int ADDR_W         = 32,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int BE_W           = XLEN / 8,
    localparam int OFF_W          = $clog2(BE_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic [1:0]        rsp_cause,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    state_e           state;
    state_e           state_nxt;
    logic [2:0]       funct_q;
    logic             we_q;
    logic [OFF_W-1:0] off_q;
    logic             accept;
    logic             legal;
    logic [BE_W-1:0]  be;
    logic [XLEN-1:0]  wdata_lane;
    logic [XLEN-1:0]  rdata_ext;
    logic             tmo_hit;

    assign accept = (state == S_IDLE) && req_valid;

    // Live request fields while idle, latched fields afterwards for load extraction.
    lsu_align #(.XLEN(XLEN)) u_align (
        .funct      ((state == S_IDLE) ? req_funct : funct_q),
        .we         ((state == S_IDLE) ? req_we : we_q),
        .offset     ((state == S_IDLE) ? req_addr[OFF_W-1:0] : off_q),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .legal      (legal),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;

    assign busy    = (state == S_ADDR) || (state == S_DATA);
    assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state_nxt != state && (state_nxt == S_ADDR || state_nxt == S_DATA))
            tmo_cnt <= '0;
        else if (busy)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (req_valid) state_nxt = legal ? S_ADDR : S_RESP;
            S_ADDR: begin
                if (mem_gnt)      state_nxt = S_DATA;
                else if (tmo_hit) state_nxt = S_RESP;
            end
            S_DATA: if (mem_rvalid || tmo_hit) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        mem_req   = (state == S_ADDR);
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct_q   <= '0;
            we_q      <= 1'b0;
            off_q     <= '0;
            rsp_rd    <= '0;
            rsp_data  <= '0;
            rsp_cause <= CAUSE_OK;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                funct_q   <= req_funct;
                we_q      <= req_we;
                off_q     <= req_addr[OFF_W-1:0];
                rsp_rd    <= req_rd;
                rsp_data  <= '0;
                rsp_cause <= legal ? CAUSE_OK : CAUSE_MISALIGN;
                mem_we    <= req_we;
                mem_be    <= be;
                mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata <= wdata_lane;
            end
            if (state == S_DATA && mem_rvalid) begin
                rsp_cause <= mem_err ? CAUSE_BUSERR : CAUSE_OK;
                rsp_data  <= (mem_err || we_q) ? '0 : rdata_ext;
            end else if (tmo_hit && !(state == S_ADDR && mem_gnt)) begin
                rsp_cause <= CAUSE_TIMEOUT;
                rsp_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu at XLEN=32 and XLEN=64.
module tb_riscv_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        rdy32, rsp_valid32, mreq32, mwe32;
    logic [31:0] rsp_data32, maddr32, mwdata32;
    logic [4:0]  rsp_rd32;
    logic [1:0]  cause32;
    logic [3:0]  mbe32;

    logic        rdy64, rsp_valid64, mreq64, mwe64;
    logic [63:0] rsp_data64, mwdata64;
    logic [31:0] maddr64;
    logic [4:0]  rsp_rd64;
    logic [1:0]  cause64;
    logic [7:0]  mbe64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid32), .req_ready(rdy32), .req_we(req_we), .req_funct(req_funct),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
        .rsp_valid(rsp_valid32), .rsp_data(rsp_data32), .rsp_rd(rsp_rd32), .rsp_cause(cause32),
        .mem_req(mreq32), .mem_gnt(mem_gnt), .mem_we(mwe32), .mem_be(mbe32),
        .mem_addr(maddr32), .mem_wdata(mwdata32), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
    );

    riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid64), .req_ready(rdy64), .req_we(req_we), .req_funct(req_funct),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid64), .rsp_data(rsp_data64), .rsp_rd(rsp_rd64), .rsp_cause(cause64),
        .mem_req(mreq64), .mem_gnt(mem_gnt), .mem_we(mwe64), .mem_be(mbe64),
        .mem_addr(maddr64), .mem_wdata(mwdata64), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; the addressed DUT accepts it.
    task automatic issue(input logic sel64, input logic we, input logic [2:0] funct,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        req_we      = we;
        req_funct   = funct;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rd      = rd;
        req_valid32 = !sel64;
        req_valid64 = sel64;
        step();
        req_valid32 = 1'b0;
        req_valid64 = 1'b0;
    endtask

    task automatic grant();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [63:0] rdata, input logic err);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        mem_err    = err;
        step();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
    endtask

    initial begin
        logic saw_rsp;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_ready", rdy32, 1);
        check("rst_mem_req", mreq32, 0);
        check("rst_rsp_valid", rsp_valid32, 0);
        check("rst_mem_be", mbe32, 0);
        check("rst_ready64", rdy64, 1);

        // SB 0x1003
        issue(0, 1, F3_B, 32'h1003, 64'hAB, 5'd1);
        check("sb_mem_req", mreq32, 1);
        check("sb_mem_we", mwe32, 1);
        check("sb_mem_be", mbe32, 4'b1000);
        check("sb_mem_addr", maddr32, 32'h1000);
        check("sb_mem_wdata", mwdata32, 32'hAB00_0000);
        check("sb_ready_busy", rdy32, 0);
        grant();
        check("sb_req_drop", mreq32, 0);
        respond(64'h0, 0);
        check("sb_rsp_valid", rsp_valid32, 1);
        check("sb_cause", cause32, CAUSE_OK);
        check("sb_rsp_data", rsp_data32, 0);
        step();
        check("sb_rsp_one_cycle", rsp_valid32, 0);

        // LB / LBU 0x2001, minimum latency
        issue(0, 0, F3_B, 32'h2001, 64'h0, 5'd7);
        check("lb_mem_be", mbe32, 4'b0010);
        check("lb_mem_we", mwe32, 0);
        grant();
        respond(64'h0000_8000, 0);
        check("lb_rsp_valid", rsp_valid32, 1);
        check("lb_rsp_data", rsp_data32, 32'hFFFF_FF80);
        check("lb_rsp_rd", rsp_rd32, 5'd7);
        step();
        issue(0, 0, F3_BU, 32'h2001, 64'h0, 5'd7);
        grant();
        respond(64'h0000_8000, 0);
        check("lbu_rsp_data", rsp_data32, 32'h0000_0080);
        check("lbu_rsp_rd", rsp_rd32, 5'd7);
        step();

        // Halfword / word lanes
        issue(0, 1, F3_H, 32'h4002, 64'h1234, 5'd2);
        check("sh_mem_be", mbe32, 4'b1100);
        check("sh_mem_wdata", mwdata32, 32'h1234_0000);
        grant();
        respond(64'h0, 0);
        step();
        issue(0, 0, F3_HU, 32'h4002, 64'h0, 5'd3);
        grant();
        respond(64'h8001_0000, 0);
        check("lhu_rsp_data", rsp_data32, 32'h0000_8001);
        step();
        issue(0, 0, F3_H, 32'h4002, 64'h0, 5'd3);
        grant();
        respond(64'h8001_0000, 0);
        check("lh_rsp_data", rsp_data32, 32'hFFFF_8001);
        step();
        issue(0, 0, F3_W, 32'h4000, 64'h0, 5'd4);
        check("lw_mem_be", mbe32, 4'b1111);
        grant();
        respond(64'h89AB_CDEF, 0);
        check("lw_rsp_data", rsp_data32, 32'h89AB_CDEF);
        step();

        // Misaligned LW: response one cycle after accept, no memory request
        issue(0, 0, F3_W, 32'h2002, 64'h0, 5'd9);
        check("mis_rsp_valid", rsp_valid32, 1);
        check("mis_cause", cause32, CAUSE_MISALIGN);
        check("mis_mem_req", mreq32, 0);
        check("mis_rsp_data", rsp_data32, 0);
        check("mis_rsp_rd", rsp_rd32, 5'd9);
        step();
        check("mis_mem_req_after", mreq32, 0);
        check("mis_ready_after", rdy32, 1);

        // Illegal encodings at XLEN=32
        issue(0, 1, F3_BU, 32'h3000, 64'h0, 5'd1);
        check("sbu_cause", cause32, CAUSE_MISALIGN);
        check("sbu_mem_req", mreq32, 0);
        step();
        issue(0, 0, F3_D, 32'h3000, 64'h0, 5'd1);
        check("ld32_cause", cause32, CAUSE_MISALIGN);
        step();
        issue(0, 0, F3_WU, 32'h8004, 64'h0, 5'd1);
        check("lwu32_cause", cause32, CAUSE_MISALIGN);
        check("lwu32_rsp_valid", rsp_valid32, 1);
        step();

        // LH with delayed grant, then bus error
        issue(0, 0, F3_H, 32'h3002, 64'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            check("gnt_wait_req", mreq32, 1);
            check("gnt_wait_be", mbe32, 4'b1100);
            check("gnt_wait_addr", maddr32, 32'h3000);
            step();
        end
        check("gnt_wait_req_last", mreq32, 1);
        grant();
        check("err_req_drop", mreq32, 0);
        step();
        check("err_no_early_rsp", rsp_valid32, 0);
        respond(64'hDEAD_BEEF, 1);
        check("err_rsp_valid", rsp_valid32, 1);
        check("err_cause", cause32, CAUSE_BUSERR);
        check("err_rsp_data", rsp_data32, 0);
        step();

        // XLEN=64
        issue(1, 0, F3_WU, 32'h8004, 64'h0, 5'd5);
        check("lwu64_mem_be", mbe64, 8'hF0);
        check("lwu64_mem_addr", maddr64, 32'h8000);
        grant();
        respond(64'hFFFF_FFFF_0000_0000, 0);
        check("lwu64_rsp_valid", rsp_valid64, 1);
        check("lwu64_rsp_data", rsp_data64, 64'h0000_0000_FFFF_FFFF);
        check("lwu64_cause", cause64, CAUSE_OK);
        check("lwu64_dut32_quiet", rsp_valid32, 0);
        step();
        issue(1, 0, F3_W, 32'h8004, 64'h0, 5'd5);
        grant();
        respond(64'hFFFF_FFFF_0000_0000, 0);
        check("lw64_rsp_data", rsp_data64, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        issue(1, 1, F3_D, 32'h8008, 64'h1122_3344_5566_7788, 5'd6);
        check("sd64_mem_be", mbe64, 8'hFF);
        check("sd64_mem_wdata", mwdata64, 64'h1122_3344_5566_7788);
        check("sd64_mem_addr", maddr64, 32'h8008);
        grant();
        respond(64'h0, 0);
        step();
        issue(1, 0, F3_D, 32'h8004, 64'h0, 5'd6);
        check("ld64_mis_cause", cause64, CAUSE_MISALIGN);
        step();

        // Reset while in DATA
        issue(0, 0, F3_W, 32'h5000, 64'h0, 5'd11);
        grant();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_ready", rdy32, 1);
        check("mid_rst_mem_req", mreq32, 0);
        check("mid_rst_rsp_valid", rsp_valid32, 0);
        check("mid_rst_rsp_rd", rsp_rd32, 0);
        check("mid_rst_rsp_data", rsp_data32, 0);
        check("mid_rst_cause", cause32, 0);
        check("mid_rst_mem_be", mbe32, 0);
        check("mid_rst_mem_addr", maddr32, 0);
        check("mid_rst_mem_wdata", mwdata32, 0);
        check("mid_rst_mem_we", mwe32, 0);
        respond(64'h1234_5678, 0);
        check("stray_rvalid_ignored", rsp_valid32, 0);
        check("stray_rvalid_ready", rdy32, 1);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: eight cycles in ADDR without a grant
        issue(0, 0, F3_B, 32'h6000, 64'h0, 5'd12);
        for (int i = 0; i < 7; i++) begin
            check("tmo_wait_req", mreq32, 1);
            step();
        end
        check("tmo_last_addr_cycle", mreq32, 1);
        step();
        check("tmo_rsp_valid", rsp_valid32, 1);
        check("tmo_cause", cause32, CAUSE_TIMEOUT);
        check("tmo_mem_req", mreq32, 0);
        check("tmo_rsp_data", rsp_data32, 0);
        step();
        check("tmo_back_idle", rdy32, 1);
`else
        // Without the watchdog the LSU waits for the grant indefinitely
        issue(0, 0, F3_B, 32'h6000, 64'h0, 5'd12);
        saw_rsp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid32) saw_rsp = 1'b1;
            step();
        end
        check("notmo_no_rsp", saw_rsp, 0);
        check("notmo_still_req", mreq32, 1);
        grant();
        respond(64'h0000_0042, 0);
        check("notmo_rsp_valid", rsp_valid32, 1);
        check("notmo_cause", cause32, CAUSE_OK);
        check("notmo_rsp_data", rsp_data32, 32'h0000_0042);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
